f2s_pulse_sched: RTL and testbench

- Fast-domain scheduler that shares one fast-to-slow pulse synchronizer channel among NREQ requesters.
- Latches single-cycle request pulses and grants them round-robin.
- Issues one tx pulse (with requester id) into the synchronizer, then waits for the synchronizer's ack, already returned to the clk domain.
- Enforces a GAP-cycle holdoff after each ack so pulses cannot merge in the slow domain.

---
 rtl/f2s_sched_pkg.sv | 20 ++
 rtl/f2s_rr_arb.sv | 29 ++
 rtl/f2s_pulse_sched.sv | 153 +++++++++++++++
 tb/tb_f2s_pulse_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/f2s_sched_pkg.sv
// Shared definitions for the fast-to-slow pulse scheduler: FSM state
// encoding and a constant-evaluable ceil(log2) helper for counter sizing.
package f2s_sched_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWaitAck = 2'd2,
    StHoldoff = 2'd3
  } state_e;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/f2s_rr_arb.sv
// Combinational rotating-priority arbiter: picks the first set pend bit at or
// above i_rr_ptr, wrapping from NREQ-1 back to 0.
module f2s_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] i_pend,
  input  logic [IDW-1:0]  i_rr_ptr,
  output logic            o_any_req,
  output logic [IDW-1:0]  o_winner
);

  // Scan NREQ positions starting at the pointer; first hit wins.
  always_comb begin
    int unsigned idx;
    o_any_req = 1'b0;
    o_winner  = '0;
    idx       = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = 32'(i_rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!o_any_req && i_pend[idx]) begin
        o_any_req = 1'b1;
        o_winner  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/f2s_pulse_sched.sv
// Fast-domain scheduler sharing one fast-to-slow pulse synchronizer among
// NREQ requesters. Request pulses are latched as pending flags, granted
// round-robin, issued as a single tx pulse with an id, and completed on the
// synchronizer's ack. A GAP-cycle holdoff after each ack keeps successive
// pulses from merging in the slow domain.
// Optional: define F2S_SCHED_TMO_EN to add an ack timeout (TMO cycles) and
// the sticky o_err flag.
module f2s_pulse_sched
  import f2s_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned GAP  = 3,
  parameter int unsigned TMO  = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req_pulse,
  output logic [NREQ-1:0] o_pend,
  output logic [NREQ-1:0] o_drop,
  output logic            o_tx_pulse,
  output logic [IDW-1:0]  o_tx_id,
  input  logic            i_tx_ack,
  output logic [NREQ-1:0] o_done,
  output logic            o_busy
`ifdef F2S_SCHED_TMO_EN
  ,
  output logic            o_err
`endif
);

  // One counter serves both holdoff and ack timeout, sized for the larger.
  localparam int unsigned CntMax = (TMO > GAP) ? TMO : GAP;
  localparam int unsigned CntW   = (clog2(CntMax + 1) > 0) ? clog2(CntMax + 1) : 1;
  localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

  state_e          r_state;
  logic [NREQ-1:0] r_pend;
  logic [NREQ-1:0] r_drop;
  logic            r_tx_pulse;
  logic [IDW-1:0]  r_tx_id;
  logic [NREQ-1:0] r_done;
  logic [IDW-1:0]  r_rr_ptr;
  logic [CntW-1:0] r_cnt;
`ifdef F2S_SCHED_TMO_EN
  logic            r_err;
`endif

  logic            w_any_req;
  logic [IDW-1:0]  w_winner;
  logic            w_grant;
  logic [NREQ-1:0] w_clr;
  logic [NREQ-1:0] w_id_oh;
  logic [IDW-1:0]  w_next_ptr;

  f2s_rr_arb #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .i_pend   (r_pend),
    .i_rr_ptr (r_rr_ptr),
    .o_any_req(w_any_req),
    .o_winner (w_winner)
  );

  // Grant decode, pending-clear mask and next round-robin pointer.
  always_comb begin
    w_grant    = (r_state == StIdle) && w_any_req;
    w_clr      = w_grant ? (OneHot0 << w_winner) : '0;
    w_id_oh    = OneHot0 << r_tx_id;
    w_next_ptr = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);
  end

  // Pending latch: a new request beats a same-cycle clear; a request against
  // an already pending, uncleared flag is reported as a drop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | i_req_pulse;
      r_drop <= i_req_pulse & r_pend & ~w_clr;
    end
  end

  // Channel FSM with registered tx/done pulses, holdoff and optional timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_tx_pulse <= 1'b0;
      r_tx_id    <= '0;
      r_done     <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
`ifdef F2S_SCHED_TMO_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_tx_pulse <= 1'b0;
      r_done     <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state    <= StIssue;
            r_tx_pulse <= 1'b1;
            r_tx_id    <= w_winner;
            r_rr_ptr   <= w_next_ptr;
          end
        end
        StIssue: begin
          r_state <= StWaitAck;
          r_cnt   <= '0;
        end
        StWaitAck: begin
          if (i_tx_ack) begin
            r_done  <= w_id_oh;
            r_cnt   <= '0;
            r_state <= (GAP > 0) ? StHoldoff : StIdle;
`ifdef F2S_SCHED_TMO_EN
          end else if (r_cnt == CntW'(TMO - 1)) begin
            // Abandon the transfer: no done, request is not re-queued.
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= (GAP > 0) ? StHoldoff : StIdle;
`endif
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StHoldoff: begin
          if (r_cnt == CntW'(GAP - 1)) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_pend     = r_pend;
  assign o_drop     = r_drop;
  assign o_tx_pulse = r_tx_pulse;
  assign o_tx_id    = r_tx_id;
  assign o_done     = r_done;
  assign o_busy     = (r_state != StIdle);
`ifdef F2S_SCHED_TMO_EN
  assign o_err      = r_err;
`endif

endmodule

// File: tb/tb_f2s_pulse_sched.sv
// Directed bench for f2s_pulse_sched (NREQ=4, IDW=2, GAP=3, TMO=8).
// Inputs are driven and outputs sampled on the falling clock edge; cycle
// numbers in comments count falling edges from the end of reset (cycle 0).
module tb_f2s_pulse_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] pend;
  logic [3:0] drop;
  logic       tx_pulse;
  logic [1:0] tx_id;
  logic [3:0] done;
  logic       busy;
`ifdef F2S_SCHED_TMO_EN
  logic       err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  f2s_pulse_sched #(
    .NREQ(4),
    .IDW (2),
    .GAP (3),
    .TMO (8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_pulse(req),
    .o_pend     (pend),
    .o_drop     (drop),
    .o_tx_pulse (tx_pulse),
    .o_tx_id    (tx_id),
    .i_tx_ack   (ack),
    .o_done     (done),
    .o_busy     (busy)
`ifdef F2S_SCHED_TMO_EN
    ,
    .o_err      (err)
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Two reset cycles; returns in cycle 0 with rst low and inputs idle.
  task automatic do_reset();
    rst = 1'b1; req = '0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; ack = 1'b1;
    tick(); tick();
    rst = 1'b0; req = '0; ack = 1'b0;
    n_chk++; if (pend !== 4'b0)     $display("FAIL reset_pend got %b want 0000", pend); else n_pass++;
    n_chk++; if (drop !== 4'b0)     $display("FAIL reset_drop got %b want 0000", drop); else n_pass++;
    n_chk++; if (tx_pulse !== 1'b0) $display("FAIL reset_tx_pulse got %b want 0", tx_pulse); else n_pass++;
    n_chk++; if (tx_id !== 2'd0)    $display("FAIL reset_tx_id got %0d want 0", tx_id); else n_pass++;
    n_chk++; if (done !== 4'b0)     $display("FAIL reset_done got %b want 0000", done); else n_pass++;
    n_chk++; if (busy !== 1'b0)     $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
`ifdef F2S_SCHED_TMO_EN
    n_chk++; if (err !== 1'b0)      $display("FAIL reset_err got %b want 0", err); else n_pass++;
`endif
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; tick(); req = '0;                                         // c1
    n_chk++; if (pend !== 4'b0100)  $display("FAIL single_pend_c1 got %b want 0100", pend); else n_pass++;
    n_chk++; if (busy !== 1'b0)     $display("FAIL single_busy_c1 got %b want 0", busy); else n_pass++;
    tick();                                                                  // c2 ISSUE
    n_chk++; if (tx_pulse !== 1'b1) $display("FAIL single_tx_c2 got %b want 1", tx_pulse); else n_pass++;
    n_chk++; if (tx_id !== 2'd2)    $display("FAIL single_id_c2 got %0d want 2", tx_id); else n_pass++;
    n_chk++; if (pend !== 4'b0000)  $display("FAIL single_pend_c2 got %b want 0000", pend); else n_pass++;
    n_chk++; if (busy !== 1'b1)     $display("FAIL single_busy_c2 got %b want 1", busy); else n_pass++;
    tick();                                                                  // c3
    n_chk++; if (tx_pulse !== 1'b0) $display("FAIL single_tx_c3 got %b want 0", tx_pulse); else n_pass++;
    n_chk++; if (tx_id !== 2'd2)    $display("FAIL single_id_hold_c3 got %0d want 2", tx_id); else n_pass++;
    tick(); tick(); ack = 1'b1;                                              // c5 ack
    tick(); ack = 1'b0;                                                      // c6
    n_chk++; if (done !== 4'b0100)  $display("FAIL single_done_c6 got %b want 0100", done); else n_pass++;
    n_chk++; if (busy !== 1'b1)     $display("FAIL single_busy_c6 got %b want 1", busy); else n_pass++;
    req = 4'b0001; tick(); req = '0;                                         // c7
    n_chk++; if (done !== 4'b0000)  $display("FAIL single_done_c7 got %b want 0000", done); else n_pass++;
    n_chk++; if (pend !== 4'b0001)  $display("FAIL single_pend_c7 got %b want 0001", pend); else n_pass++;
    tick(); tick();                                                          // c9 IDLE
    n_chk++; if (busy !== 1'b0)     $display("FAIL single_busy_c9 got %b want 0", busy); else n_pass++;
    n_chk++; if (tx_pulse !== 1'b0) $display("FAIL single_tx_c9 got %b want 0", tx_pulse); else n_pass++;
    tick();                                                                  // c10 = 5+3+2
    n_chk++; if (tx_pulse !== 1'b1) $display("FAIL single_tx_c10 got %b want 1", tx_pulse); else n_pass++;
    n_chk++; if (tx_id !== 2'd0)    $display("FAIL single_id_c10 got %0d want 0", tx_id); else n_pass++;
    tick(); ack = 1'b1; tick(); ack = 1'b0;                                  // c12
    n_chk++; if (done !== 4'b0001)  $display("FAIL single_done_c12 got %b want 0001", done); else n_pass++;
  endtask

  task automatic test_round_robin();
    int         exp_id[5] = '{0, 1, 2, 3, 0};
    int         waited;
    logic [3:0] oh;
    do_reset();
    req = 4'b1111; tick(); req = '0;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (tx_pulse !== 1'b1 && waited < 20) begin tick(); waited++; end
      n_chk++;
      if (tx_pulse !== 1'b1) $display("FAIL rr_issue_%0d got no tx_pulse want one within 20 cycles", g);
      else if (tx_id !== 2'(exp_id[g])) $display("FAIL rr_id_%0d got %0d want %0d", g, tx_id, exp_id[g]);
      else n_pass++;
      tick(); tick(); tick(); ack = 1'b1;
      tick(); ack = 1'b0;
      oh = 4'b0001 << exp_id[g];
      n_chk++; if (done !== oh) $display("FAIL rr_done_%0d got %b want %b", g, done, oh); else n_pass++;
      req = oh; tick(); req = '0;
    end
  endtask

  task automatic test_drop_set_wins();
    do_reset();
    req = 4'b0001; tick(); req = '0;                                         // c1
    tick(); req = 4'b0010;                                                   // c2 ISSUE id0
    tick(); req = '0;                                                        // c3
    tick(); req = 4'b0010;                                                   // c4 extra req
    tick();                                                                  // c5 extra req
    n_chk++; if (drop !== 4'b0010)  $display("FAIL drop_c5 got %b want 0010", drop); else n_pass++;
    tick(); req = '0;                                                        // c6
    n_chk++; if (drop !== 4'b0010)  $display("FAIL drop_c6 got %b want 0010", drop); else n_pass++;
    tick();                                                                  // c7
    n_chk++; if (drop !== 4'b0000)  $display("FAIL drop_c7 got %b want 0000", drop); else n_pass++;
    n_chk++; if (pend !== 4'b0010)  $display("FAIL drop_pend_c7 got %b want 0010", pend); else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0;                                          // c8 done id0
    tick(); tick(); tick(); req = 4'b0010;                                   // c11 IDLE, clear pend1
    tick(); req = '0;                                                        // c12 ISSUE id1
    n_chk++; if (tx_pulse !== 1'b1) $display("FAIL setwin_tx_c12 got %b want 1", tx_pulse); else n_pass++;
    n_chk++; if (tx_id !== 2'd1)    $display("FAIL setwin_id_c12 got %0d want 1", tx_id); else n_pass++;
    n_chk++; if (pend !== 4'b0010)  $display("FAIL setwin_pend_c12 got %b want 0010", pend); else n_pass++;
    n_chk++; if (drop !== 4'b0000)  $display("FAIL setwin_drop_c12 got %b want 0000", drop); else n_pass++;
  endtask

  task automatic test_spurious_ack();
    do_reset();
    ack = 1'b1; tick(); ack = 1'b0;                                          // c1 ack in IDLE
    n_chk++; if (done !== 4'b0000)  $display("FAIL spur_idle_done got %b want 0000", done); else n_pass++;
    n_chk++; if (busy !== 1'b0)     $display("FAIL spur_idle_busy got %b want 0", busy); else n_pass++;
    req = 4'b0100; tick(); req = '0;                                         // c2
    tick();                                                                  // c3 ISSUE
    n_chk++; if (tx_pulse !== 1'b1) $display("FAIL spur_tx_c3 got %b want 1", tx_pulse); else n_pass++;
    tick(); ack = 1'b1; tick(); ack = 1'b0;                                  // c5
    n_chk++; if (done !== 4'b0100)  $display("FAIL spur_done_c5 got %b want 0100", done); else n_pass++;
    tick(); ack = 1'b1; tick(); ack = 1'b0;                                  // c7 ack in HOLDOFF c6
    n_chk++; if (done !== 4'b0000)  $display("FAIL spur_hold_done got %b want 0000", done); else n_pass++;
    n_chk++; if (busy !== 1'b1)     $display("FAIL spur_hold_busy_c7 got %b want 1", busy); else n_pass++;
    tick();                                                                  // c8 IDLE
    n_chk++; if (busy !== 1'b0)     $display("FAIL spur_busy_c8 got %b want 0", busy); else n_pass++;
    n_chk++; if (tx_pulse !== 1'b0) $display("FAIL spur_tx_c8 got %b want 0", tx_pulse); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010; tick(); req = '0;                                         // c1
    tick();                                                                  // c2 ISSUE id1
    n_chk++; if (tx_id !== 2'd1)    $display("FAIL rmid_id_c2 got %0d want 1", tx_id); else n_pass++;
    tick(); tick(); rst = 1'b1; req = 4'b0001; ack = 1'b1;                   // c4 WAIT_ACK
    tick(); rst = 1'b0; req = '0; ack = 1'b0;                                // c5
    n_chk++; if (pend !== 4'b0000)  $display("FAIL rmid_pend got %b want 0000", pend); else n_pass++;
    n_chk++; if (done !== 4'b0000)  $display("FAIL rmid_done got %b want 0000", done); else n_pass++;
    n_chk++; if (busy !== 1'b0)     $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (tx_id !== 2'd0)    $display("FAIL rmid_tx_id got %0d want 0", tx_id); else n_pass++;
    req = 4'b0101; tick(); req = '0;                                         // c6
    n_chk++; if (done !== 4'b0000)  $display("FAIL rmid_done_c6 got %b want 0000", done); else n_pass++;
    tick();                                                                  // c7 ISSUE
    n_chk++; if (tx_id !== 2'd0)    $display("FAIL rmid_ptr_id got %0d want 0", tx_id); else n_pass++;
    n_chk++; if (tx_pulse !== 1'b1) $display("FAIL rmid_tx_c7 got %b want 1", tx_pulse); else n_pass++;
  endtask

`ifdef F2S_SCHED_TMO_EN
  task automatic test_timeout();
    do_reset();
    req = 4'b0011; tick(); req = '0;                                         // c1
    tick();                                                                  // c2 ISSUE id0
    n_chk++; if (tx_id !== 2'd0)    $display("FAIL tmo_id_c2 got %0d want 0", tx_id); else n_pass++;
    repeat (8) tick();                                                       // c10 last WAIT_ACK
    n_chk++; if (err !== 1'b0)      $display("FAIL tmo_err_c10 got %b want 0", err); else n_pass++;
    tick();                                                                  // c11 HOLDOFF
    n_chk++; if (err !== 1'b1)      $display("FAIL tmo_err_c11 got %b want 1", err); else n_pass++;
    n_chk++; if (done !== 4'b0000)  $display("FAIL tmo_done got %b want 0000", done); else n_pass++;
    n_chk++; if (pend !== 4'b0010)  $display("FAIL tmo_pend got %b want 0010", pend); else n_pass++;
    repeat (4) tick();                                                       // c15 ISSUE id1
    n_chk++; if (tx_pulse !== 1'b1) $display("FAIL tmo_next_tx got %b want 1", tx_pulse); else n_pass++;
    n_chk++; if (tx_id !== 2'd1)    $display("FAIL tmo_next_id got %0d want 1", tx_id); else n_pass++;
    tick(); ack = 1'b1; tick(); ack = 1'b0;
    n_chk++; if (err !== 1'b1)      $display("FAIL tmo_err_sticky got %b want 1", err); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; ack = 1'b0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_drop_set_wins();
    test_spurious_ack();
    test_reset_mid();
`ifdef F2S_SCHED_TMO_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
